// File: rtl/ntt_ctrl_pkg.sv
// Shared NTT pipeline control types: stage FSM encoding and transform geometry helpers.
// Pure declarations, no logic; imported by every stage controller.
package ntt_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ctrl_state_t;

   // Transform length N = 2^logn.
   function automatic int calc_n(input int logn);
      return 1 << logn;
   endfunction

   // SDF feedback delay D = 2^(logn-1-stage).
   function automatic int calc_d(input int logn, input int stage);
      return 1 << (logn - 1 - stage);
   endfunction

endpackage

// File: rtl/shiftreg.sv
// Enable-gated delay line, DEPTH cycles (shifts) deep, W bits wide.
// Shifts only when en is high; contents hold otherwise.
module shiftreg #(
   parameter int W     = 1,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] pipe [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else if (en) begin
         pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[DEPTH-1];

endmodule

// File: rtl/btf_stage_ctrl.sv
// SDF butterfly stage controller: fill/butterfly select, twiddle address, FIFO write, out_valid after BTF_LAT.
// Define BTF_CTRL_STALL_EN to let in_valid gaps stall cnt and the valid pipe; otherwise the stream is contiguous.
module btf_stage_ctrl
   import ntt_ctrl_pkg::*;
#(
   parameter int LOGN    = 4,
   parameter int STAGE   = 0,
   parameter int BTF_LAT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            intt,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            btf_sel,
   output logic            fifo_we,
   output logic [LOGN-1:0] tw_addr,
   output logic            out_valid,
   output logic            busy,
   output logic            done
);

   localparam int N         = calc_n(LOGN);
   localparam int D         = calc_d(LOGN, STAGE);
   localparam int DRAIN_LEN = D + BTF_LAT;
   localparam int DW        = $clog2(DRAIN_LEN + 1);
   localparam int LB        = LOGN - 1;

   ctrl_state_t     state;
   logic [LOGN-1:0] cnt;
   logic [DW-1:0]   dcnt;
   logic            intt_q;
   logic            done_q;

   logic            in_run, in_drain, acc, adv, sr_en, sr_d, sr_q;
   logic [LB-1:0]   cnt_mod, tw_low;

   assign in_run   = (state == ST_RUN);
   assign in_drain = (state == ST_DRAIN);
   assign acc      = in_valid & in_run;

`ifdef BTF_CTRL_STALL_EN
   assign adv   = acc;
   assign sr_en = acc | in_drain;
`else
   assign adv   = in_run;
   assign sr_en = 1'b1;
`endif

   // The first D fill slots have nothing in the FIFO to emit; the last D come out during drain.
   assign sr_d = (adv & (cnt >= LOGN'(D))) | (in_drain & (dcnt < DW'(D)));

   shiftreg #(.W(1), .DEPTH(BTF_LAT)) u_vpipe (
      .clk (clk),
      .rst (rst),
      .en  (sr_en),
      .d   (sr_d),
      .q   (sr_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         dcnt   <= '0;
         intt_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               // done_q high means this is the completion cycle; a start here is ignored.
               if (start && !done_q) begin
                  state  <= ST_RUN;
                  intt_q <= intt;
                  cnt    <= '0;
               end
            end
            ST_RUN: begin
               if (adv) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LOGN'(N - 1)) begin
                     state <= ST_DRAIN;
                     dcnt  <= '0;
                  end
               end
            end
            ST_DRAIN: begin
               if (dcnt == DW'(DRAIN_LEN - 1)) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cnt_mod   = cnt[LB-1:0] & LB'(D - 1);
   assign tw_low    = cnt_mod << STAGE;
   assign tw_addr   = {intt_q, tw_low};
   assign btf_sel   = in_run & cnt[LOGN-1-STAGE];
   assign in_ready  = in_run;
   assign fifo_we   = acc | in_drain;
   assign out_valid = sr_q & sr_en;
   assign busy      = in_run | in_drain;
   assign done      = done_q;

endmodule

// File: tb/tb_btf_stage_ctrl.sv
// Bench for btf_stage_ctrl: STAGE=0 and STAGE=2 instances on a shared stimulus stream,
// out_valid timing checked against a queue of expected arrival cycles.
module tb_btf_stage_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       intt = 1'b0;
   logic       in_valid = 1'b0;

   logic       in_ready, btf_sel, fifo_we, out_valid, busy, done;
   logic [3:0] tw_addr;
   logic       in_ready2, btf_sel2, fifo_we2, out_valid2, busy2, done2;
   logic [3:0] tw_addr2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ov_seen = 0;
   int ov_seen2 = 0;
   bit mon2_en = 1'b1;
   int exp_q[$];
   int exp2_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   btf_stage_ctrl #(.LOGN(4), .STAGE(0), .BTF_LAT(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .intt(intt), .in_valid(in_valid),
      .in_ready(in_ready), .btf_sel(btf_sel), .fifo_we(fifo_we), .tw_addr(tw_addr),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   btf_stage_ctrl #(.LOGN(4), .STAGE(2), .BTF_LAT(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .intt(intt), .in_valid(in_valid),
      .in_ready(in_ready2), .btf_sel(btf_sel2), .fifo_we(fifo_we2), .tw_addr(tw_addr2),
      .out_valid(out_valid2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // Scoreboard side: each out_valid pops the arrival cycle predicted when the slot was driven.
   always @(negedge clk) begin
      int e;
      if (!rst && out_valid) begin
         ov_seen++;
         if (exp_q.size() == 0) chk("ov_unexpected", out_valid, 0);
         else begin
            e = exp_q.pop_front();
`ifndef BTF_CTRL_STALL_EN
            chk("ov_cycle", cyc, e);
`endif
         end
      end
      if (!rst && mon2_en && out_valid2) begin
         ov_seen2++;
         if (exp2_q.size() == 0) chk("ov2_unexpected", out_valid2, 0);
         else begin
            e = exp2_q.pop_front();
`ifndef BTF_CTRL_STALL_EN
            chk("ov2_cycle", cyc, e);
`endif
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_btf_sel"}, btf_sel, 0);
      chk({tag, "_fifo_we"}, fifo_we, 0);
      chk({tag, "_tw_addr"}, tw_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy2"}, busy2, 0);
      chk({tag, "_tw_addr2"}, tw_addr2, 0);
      chk({tag, "_out_valid2"}, out_valid2, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      exp2_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mon2_en = 1'b1;
   endtask

   task automatic run(input bit intt_v, input bit toggle, input bit use_gap,
                      input int abort_at, input bit hold);
      int  m = 0;
      int  gap = 0;
      bit  gapped = 0;
      bit  adv;
      int  last_j;
      ov_seen  = 0;
      ov_seen2 = 0;
      @(posedge clk); #1;
      start = 1'b1;
      intt  = intt_v;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 0);
      while (m < 16) begin
         @(posedge clk); #1;
         start = hold;
         if (toggle) intt = ~intt;
         if (use_gap && m == 5 && !gapped) begin gap = 3; gapped = 1; end
         in_valid = (gap == 0);
         if (gap > 0) gap--;
         @(negedge clk);
         chk("run_in_ready", in_ready, 1);
         chk("run_busy", busy, 1);
         chk("run_btf_sel", btf_sel, (m >= 8));
         chk("run_tw_addr", tw_addr, intt_v * 8 + (m % 8));
         chk("run_fifo_we", fifo_we, in_valid);
         chk("run_done", done, 0);
         chk("run2_btf_sel", btf_sel2, (m / 2) % 2);
         chk("run2_tw_addr", tw_addr2, intt_v * 8 + (m % 2) * 4);
         chk("run2_busy", busy2, 1);
`ifdef BTF_CTRL_STALL_EN
         adv = in_valid;
`else
         adv = 1'b1;
`endif
         if (adv && m >= 8) exp_q.push_back(cyc + 4);
         if (adv && m >= 2) exp2_q.push_back(cyc + 4);
         if (m == abort_at) begin
            #1 rst = 1'b1;
            #1 chk_all_zero("abort");
            exp_q.delete();
            exp2_q.delete();
            repeat (2) begin
               @(negedge clk);
               chk("abort_done", done, 0);
               chk("abort_done2", done2, 0);
            end
            rst = 1'b0;
            in_valid = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk("abort_post_done", done, 0);
            chk("abort_post_busy", busy, 0);
            return;
         end
         if (adv) m++;
      end
      last_j = hold ? 14 : 12;
      for (int j = 0; j <= last_j; j++) begin
         @(posedge clk); #1;
         start = hold;
         in_valid = 1'b0;
         @(negedge clk);
         if (hold && j >= 7) mon2_en = 1'b0;
         if (j < 12) begin
            chk("drain_busy", busy, 1);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_fifo_we", fifo_we, 1);
            chk("drain_btf_sel", btf_sel, 0);
            chk("drain_done", done, 0);
            if (j < 8) exp_q.push_back(cyc + 4);
         end else if (j == 12) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_fifo_we", fifo_we, 0);
            chk("ov_count", ov_seen, 16);
            chk("sb_empty", exp_q.size(), 0);
         end else if (j == 13) begin
            chk("hold_no_restart", busy, 0);
            chk("hold_done_once", done, 0);
         end else begin
            chk("hold_restart", busy, 1);
         end
         if (mon2_en) begin
            chk("drain2_busy", busy2, (j < 6));
            chk("drain2_done", done2, (j == 6));
            if (j < 2) exp2_q.push_back(cyc + 4);
            if (j == 6) begin
               chk("ov2_count", ov_seen2, 16);
               chk("sb2_empty", exp2_q.size(), 0);
            end
         end
      end
      start = 1'b0;
      if (hold) do_reset();
   endtask

   initial begin
      #2 chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      run(1'b0, 1'b0, 1'b0, -1, 1'b0);   // contiguous forward run
      run(1'b1, 1'b1, 1'b1, -1, 1'b0);   // inverse, intt toggling, in_valid gap at cnt=5
      run(1'b0, 1'b0, 1'b0, 10, 1'b0);   // reset mid-run at cnt=10
      run(1'b0, 1'b0, 1'b0, -1, 1'b0);   // clean run after abort
      run(1'b1, 1'b0, 1'b0, -1, 1'b1);   // start held high across done
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/btf_stage_ctrl.md
BTF_STAGE_CTRL -- requirements
Module: btf_stage_ctrl

Interface
REQ-001 SHALL have parameter LOGN, default 4: log2 of transform length N.
REQ-002 SHALL have parameter STAGE, default 0: SDF stage index; feedback delay D = 2^(LOGN-1-STAGE).
REQ-003 SHALL have parameter BTF_LAT, default 4: butterfly datapath latency in cycles (multiply + reduce + add/sub).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: start in 1 run request pulse; intt in 1 inverse-transform select, sampled with start.
REQ-006 SHALL have ports: in_valid in 1 sample strobe; in_ready out 1 high while accepting samples.
REQ-007 SHALL have ports: btf_sel out 1 (0 = fill/pass, 1 = butterfly); fifo_we out 1 feedback FIFO write enable.
REQ-008 SHALL have port tw_addr out LOGN bits: twiddle ROM address, with MSB = latched intt.
REQ-009 SHALL have ports: out_valid out 1 output sample strobe; busy out 1; done out 1 single-cycle completion pulse.

Function
REQ-010 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-011 SHALL leave IDLE for RUN on start=1, latch intt, and clear the sample counter cnt (LOGN bits).
REQ-012 SHALL hold in_ready=1 only in RUN; an accepted sample is in_valid & in_ready.
REQ-013 SHALL increment cnt on each accepted sample; cnt wraps to 0 after N-1, and that same accept moves the FSM to DRAIN.
REQ-014 SHALL set btf_sel = cnt bit (LOGN-1-STAGE) during RUN, i.e. the first D of every 2D block is fill and the next D is butterfly.
REQ-015 SHALL assert fifo_we on every accepted sample and on every DRAIN cycle.
REQ-016 SHALL drive tw_addr low bits = (cnt mod D) << STAGE, zero-extended to LOGN-1 bits, as combinational outputs with no added latency.
REQ-017 SHALL delay the accept strobe (butterfly slots) by BTF_LAT cycles to form out_valid; fill-slot outputs carry the same BTF_LAT alignment.
REQ-018 SHALL stay in DRAIN for exactly D+BTF_LAT cycles, asserting out_valid for D of them to flush the FIFO, then pulse done for 1 cycle and return to IDLE.
REQ-019 SHALL hold busy=1 in RUN and DRAIN.
REQ-020 SHALL ignore start while busy, including a start in the same cycle as done.
REQ-021 SHALL produce exactly N out_valid pulses per run.

Reset
REQ-022 SHALL, on rst=1 and asynchronously, force IDLE with cnt=0, valid pipe cleared, and all outputs 0, including mid-RUN and mid-DRAIN.
REQ-023 SHALL NOT emit done for a run aborted by reset.

Configuration
REQ-024 SHALL, with BTF_CTRL_STALL_EN defined, advance cnt and the valid pipe only on accepted samples, so in_valid gaps stall the stage.
REQ-025 SHALL, without BTF_CTRL_STALL_EN, advance cnt every RUN cycle regardless of in_valid, since the stream is contiguous from the cycle after start.

Structure
REQ-026 SHALL take the FSM state encodings and the D / N derivation functions from shared package ntt_ctrl_pkg.
REQ-027 SHALL realise the BTF_LAT valid delay with one instance of the existing shiftreg sub-module.

Verification (LOGN=4, STAGE=0, BTF_LAT=4, so N=16, D=8)
REQ-028 Contiguous run: start, then 16 valid cycles -> btf_sel 0 for cnt 0-7 and 1 for cnt 8-15, tw_addr 0..7, 16 out_valid pulses, done 12 cycles after the last accept.
REQ-029 intt=1 at start -> tw_addr MSB=1 for the entire run; intt toggling mid-run has no effect.
REQ-030 STAGE=2 (D=2) -> btf_sel pattern 0,0,1,1 repeating, tw_addr low bits 0,4,0,4.
REQ-031 Stall (macro defined): in_valid low for 3 cycles at cnt=5 -> cnt holds at 5, btf_sel and tw_addr stable, total out_valid pulses still 16.
REQ-032 rst asserted at cnt=10 -> outputs 0 within the same cycle, no done, and the next start runs normally from cnt=0.
REQ-033 start held high across done -> no restart until one IDLE cycle has elapsed.
